// File: rtl/wb_stage.sv
`default_nettype none
// ============================================================================
// Module : wb_stage
// Registered writeback stage: source select, load-response wait, kill/x0
// write gating, forwarding qualifier and retired-instruction counter.
// Rev    : 1.0
// ============================================================================
module wb_stage #(
    parameter int DATA_WIDTH = 32,
    parameter int NUM_SRC    = 4,
    parameter int SEL_WIDTH  = 2,
    parameter int MEM_IDX    = 1,
    parameter int CNT_WIDTH  = 32
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [NUM_SRC*DATA_WIDTH-1:0] src_data,
    input  logic [SEL_WIDTH-1:0]          wb_sel,
    input  logic                          reg_write_in,
    input  logic                          kill_wb,
    input  logic [4:0]                    rd_in,
    input  logic                          mem_rvalid,
    input  logic [DATA_WIDTH-1:0]         mem_rdata,
    output logic                          rd_we,
    output logic [4:0]                    rd_addr,
    output logic [DATA_WIDTH-1:0]         rd_wdata,
    output logic                          fwd_valid,
    output logic [CNT_WIDTH-1:0]          retire_count,
    output logic                          busy
);

    typedef enum logic [0:0] {
        ST_IDLE     = 1'b0,
        ST_WAIT_MEM = 1'b1
    } state_t;

    localparam logic [SEL_WIDTH-1:0] c_mem_sel = SEL_WIDTH'(MEM_IDX);
    localparam logic [CNT_WIDTH-1:0] c_cnt_one = CNT_WIDTH'(1);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_rd_we;
    logic [4:0]            r_rd_addr;
    logic [DATA_WIDTH-1:0] r_rd_wdata;
    logic [CNT_WIDTH-1:0]  r_cnt;
    logic [4:0]            r_p_rd;
    logic                  r_p_we;
    logic                  r_p_kill;

    logic [DATA_WIDTH-1:0] w_src [NUM_SRC];
    logic [DATA_WIDTH-1:0] w_src_val;
    logic                  w_commit;
    logic                  w_latch;
    logic [4:0]            w_c_rd;
    logic                  w_c_req;
    logic                  w_c_kill;
    logic [DATA_WIDTH-1:0] w_c_data;

    for (genvar g = 0; g < NUM_SRC; g++) begin : g_src
        assign w_src[g] = src_data[g*DATA_WIDTH +: DATA_WIDTH];
    end

    // Selects beyond NUM_SRC match no source and fall through to zero.
    always_comb begin
        w_src_val = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (wb_sel == SEL_WIDTH'(i)) begin
                w_src_val = w_src[i];
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_commit    = 1'b0;
        w_latch     = 1'b0;
        w_c_rd      = rd_in;
        w_c_req     = reg_write_in;
        w_c_kill    = kill_wb;
        w_c_data    = w_src_val;
        case (r_state)
            ST_IDLE: begin
                if (in_valid) begin
                    if (wb_sel == c_mem_sel) begin
                        if (mem_rvalid) begin
                            w_commit = 1'b1;
                            w_c_data = mem_rdata;
                        end else begin
                            w_latch     = 1'b1;
                            w_state_nxt = ST_WAIT_MEM;
                        end
                    end else begin
                        w_commit = 1'b1;
                    end
                end
            end
            ST_WAIT_MEM: begin
                // A kill arriving on the response cycle still cancels the load.
                w_c_rd   = r_p_rd;
                w_c_req  = r_p_we;
                w_c_kill = r_p_kill | kill_wb;
                w_c_data = mem_rdata;
                if (mem_rvalid) begin
                    w_commit    = 1'b1;
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_IDLE;
            r_rd_we    <= 1'b0;
            r_rd_addr  <= '0;
            r_rd_wdata <= '0;
            r_cnt      <= '0;
            r_p_rd     <= '0;
            r_p_we     <= 1'b0;
            r_p_kill   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_rd_we <= w_commit && w_c_req && !w_c_kill && (w_c_rd != 5'd0);
            if (w_commit) begin
                r_rd_addr  <= w_c_rd;
                r_rd_wdata <= w_c_data;
                if (!w_c_kill) begin
                    r_cnt <= r_cnt + c_cnt_one;
                end
            end
            if (w_latch) begin
                r_p_rd   <= rd_in;
                r_p_we   <= reg_write_in;
                r_p_kill <= kill_wb;
            end else if (r_state == ST_WAIT_MEM) begin
                r_p_kill <= r_p_kill | kill_wb;
            end
        end
    end

    assign in_ready     = (r_state == ST_IDLE);
    assign busy         = (r_state == ST_WAIT_MEM);
    assign rd_we        = r_rd_we;
    assign fwd_valid    = r_rd_we;
    assign rd_addr      = r_rd_addr;
    assign rd_wdata     = r_rd_wdata;
    assign retire_count = r_cnt;

endmodule
`default_nettype wire

// File: tb/tb_wb_stage.sv
`default_nettype none
// Testbench for wb_stage: randomized and directed stimulus with a queue-based
// scoreboard fed by a transaction-level model of the writeback stage.
module tb_wb_stage;

    localparam int DW = 32;
    localparam int NS = 3;
    localparam int SW = 2;
    localparam int MI = 1;
    localparam int CW = 8;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              in_valid = 1'b0;
    logic              in_ready;
    logic [NS*DW-1:0]  src_data;
    logic [SW-1:0]     wb_sel = '0;
    logic              reg_write_in = 1'b0;
    logic              kill_wb = 1'b0;
    logic [4:0]        rd_in = '0;
    logic              mem_rvalid = 1'b0;
    logic [DW-1:0]     mem_rdata = '0;
    logic              rd_we;
    logic [4:0]        rd_addr;
    logic [DW-1:0]     rd_wdata;
    logic              fwd_valid;
    logic [CW-1:0]     retire_count;
    logic              busy;
    logic [DW-1:0]     src_v [NS] = '{default: '0};

    assign src_data = {src_v[2], src_v[1], src_v[0]};

    wb_stage #(
        .DATA_WIDTH(DW), .NUM_SRC(NS), .SEL_WIDTH(SW), .MEM_IDX(MI), .CNT_WIDTH(CW)
    ) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .src_data(src_data), .wb_sel(wb_sel), .reg_write_in(reg_write_in),
        .kill_wb(kill_wb), .rd_in(rd_in), .mem_rvalid(mem_rvalid),
        .mem_rdata(mem_rdata), .rd_we(rd_we), .rd_addr(rd_addr),
        .rd_wdata(rd_wdata), .fwd_valid(fwd_valid),
        .retire_count(retire_count), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        int            due;
        bit            we;
        logic [4:0]    addr;
        logic [DW-1:0] data;
        logic [CW-1:0] cnt;
    } exp_t;

    exp_t       sb[$];
    int         n_tests = 0;
    int         n_fail  = 0;
    int         cyc     = 0;
    bit         pend    = 1'b0;
    bit         p_we    = 1'b0;
    bit         p_kill  = 1'b0;
    logic [4:0] p_rd    = '0;
    int         model_cnt = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One completed instruction: its result appears on the outputs next cycle.
    task automatic commit(input logic [4:0] rd, input bit rw, input bit k, input logic [DW-1:0] d);
        exp_t e;
        if (!k) model_cnt = (model_cnt + 1) % (1 << CW);
        e.due  = cyc + 1;
        e.we   = rw && !k && (rd != 5'd0);
        e.addr = rd;
        e.data = d;
        e.cnt  = CW'(model_cnt);
        sb.push_back(e);
    endtask

    task automatic step(input bit v, input int sel, input bit rw, input bit k,
                        input logic [4:0] rd, input bit rv, input logic [DW-1:0] rdata,
                        input logic [DW-1:0] s0, input logic [DW-1:0] s1,
                        input logic [DW-1:0] s2);
        logic [DW-1:0] d;
        @(negedge clk);
        chk("in_ready", in_ready, DW'(!pend));
        chk("busy", busy, DW'(pend));
        in_valid = v; wb_sel = SW'(sel); reg_write_in = rw; kill_wb = k;
        rd_in = rd; mem_rvalid = rv; mem_rdata = rdata;
        src_v[0] = s0; src_v[1] = s1; src_v[2] = s2;
        case (sel)
            0: d = s0;
            1: d = s1;
            2: d = s2;
            default: d = '0;
        endcase
        if (!pend) begin
            if (v) begin
                if (sel == MI) begin
                    if (rv) commit(rd, rw, k, rdata);
                    else begin
                        pend = 1'b1; p_rd = rd; p_we = rw; p_kill = k;
                    end
                end else begin
                    commit(rd, rw, k, d);
                end
            end
        end else begin
            p_kill = p_kill | k;
            if (rv) begin
                commit(p_rd, p_we, p_kill, rdata);
                pend = 1'b0;
            end
        end
    endtask

    task automatic idle(input bit rv, input bit k);
        step(1'b0, 0, 1'b0, k, 5'd0, rv, 32'h5A5A_0000 + DW'(cyc), 32'h0, 32'h0, 32'h0);
    endtask

    // Scoreboard monitor: a due entry must match; otherwise no write may appear.
    always @(negedge clk) begin
        exp_t e;
        if (sb.size() > 0 && sb[0].due < cyc) begin
            e = sb.pop_front();
            chk("sb_missed_entry", DW'(e.due), DW'(cyc));
        end
        if (sb.size() > 0 && sb[0].due == cyc) begin
            e = sb.pop_front();
            chk("rd_we", DW'(rd_we), DW'(e.we));
            chk("fwd_valid", DW'(fwd_valid), DW'(e.we));
            chk("rd_addr", DW'(rd_addr), DW'(e.addr));
            chk("rd_wdata", rd_wdata, e.data);
            chk("retire_count", DW'(retire_count), DW'(e.cnt));
        end else begin
            chk("rd_we_idle", DW'(rd_we), 32'd0);
            chk("fwd_valid_idle", DW'(fwd_valid), 32'd0);
        end
    end

    initial begin
        #500000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        repeat (2) @(negedge clk);
        chk("reset_rd_addr", DW'(rd_addr), 32'd0);
        chk("reset_rd_wdata", rd_wdata, 32'd0);
        chk("reset_count", DW'(retire_count), 32'd0);
        chk("reset_in_ready", DW'(in_ready), 32'd1);
        rst = 1'b0;

        // ALU result to x5
        step(1, 0, 1, 0, 5'd5, 0, 0, 32'h1234_5678, 32'h0, 32'h0);
        idle(0, 0);
        chk("t1_rd_we", DW'(rd_we), 32'd1);
        chk("t1_rd_addr", DW'(rd_addr), 32'd5);
        chk("t1_rd_wdata", rd_wdata, 32'h1234_5678);
        chk("t1_count", DW'(retire_count), 32'd1);

        // Load waiting three cycles for its response
        step(1, 1, 1, 0, 5'd7, 0, 0, 32'h1, 32'h2, 32'h3);
        idle(0, 0); idle(0, 0);
        step(0, 0, 0, 0, 5'd0, 1, 32'hFFFF_FF80, 32'h0, 32'h0, 32'h0);
        idle(0, 0);
        chk("t2_rd_we", DW'(rd_we), 32'd1);
        chk("t2_rd_wdata", rd_wdata, 32'hFFFF_FF80);
        chk("t2_rd_addr", DW'(rd_addr), 32'd7);

        // Load killed while waiting
        step(1, 1, 1, 0, 5'd8, 0, 0, 32'h0, 32'h0, 32'h0);
        idle(0, 1);
        step(0, 0, 0, 0, 5'd0, 1, 32'hDEAD_BEEF, 32'h0, 32'h0, 32'h0);
        idle(0, 0);
        chk("t3_rd_we", DW'(rd_we), 32'd0);
        chk("t3_count", DW'(retire_count), 32'd2);

        // x0 destination, then an out-of-range select
        step(1, 2, 1, 0, 5'd0, 0, 0, 32'h0, 32'h0, 32'h104);
        idle(0, 0);
        chk("t4_x0_we", DW'(rd_we), 32'd0);
        chk("t4_x0_count", DW'(retire_count), 32'd3);
        step(1, 3, 1, 0, 5'd9, 0, 0, 32'h11, 32'h22, 32'h33);
        idle(0, 0);
        chk("t4_sel3_wdata", rd_wdata, 32'd0);

        // Back-to-back ALU writes
        for (int i = 1; i <= 4; i++)
            step(1, 0, 1, 0, 5'(i), 0, 0, 32'hA000_0000 + DW'(i), 32'h0, 32'h0);
        idle(0, 0); idle(0, 0);

        // Asynchronous reset while a load is pending
        step(1, 1, 1, 0, 5'd10, 0, 0, 32'h0, 32'h0, 32'h0);
        idle(0, 0);
        #2 rst = 1'b1;
        #1;
        chk("t6_rst_we", DW'(rd_we), 32'd0);
        chk("t6_rst_addr", DW'(rd_addr), 32'd0);
        chk("t6_rst_wdata", rd_wdata, 32'd0);
        chk("t6_rst_count", DW'(retire_count), 32'd0);
        chk("t6_rst_busy", DW'(busy), 32'd0);
        pend = 1'b0; model_cnt = 0;
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        step(0, 0, 0, 0, 5'd0, 1, 32'hBAD0_BAD0, 32'h0, 32'h0, 32'h0);
        idle(0, 0); idle(0, 0);

        // Counter wrap at 2^CW retirements
        for (int i = 0; i < (1 << CW); i++)
            step(1, 0, 1, 0, 5'(1 + i % 31), 0, 0, DW'(i), 32'h0, 32'h0);
        idle(0, 0);
        chk("t7_wrap", DW'(retire_count), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 600; n++) begin
            step(($urandom % 4) != 0, int'($urandom_range(0, 3)), ($urandom % 4) != 0,
                 ($urandom % 8) == 0, 5'($urandom_range(0, 31)),
                 pend ? (($urandom % 3) == 0) : (($urandom % 2) == 0),
                 $urandom, $urandom, $urandom, $urandom);
        end
        for (int n = 0; n < 4 && pend; n++) idle(1, 0);
        idle(0, 0); idle(0, 0);
        chk("sb_drained", DW'(sb.size()), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
